// File: rtl/pd_result_collector.sv
// Per-frame top-N collector for HOG+SVM pedestrian hits: keeps the best detections sorted,
// snapshots them at frame end and streams the snapshot out over valid/ready.
module pd_result_collector #(
    parameter int MAX_DET  = 8,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int GW       = 16,
    parameter int GRADE_TH = 0
) (
    input  logic          RGB565_PCLK,
    input  logic          RESETN,
    input  logic          svm_judge_res,
    input  logic [2:0]    svm_judge_res_scale,
    input  logic [HW-1:0] svm_judge_HCnt,
    input  logic [VW-1:0] svm_judge_VCnt,
    input  logic [GW-1:0] svm_judge_res_grade,
    input  logic          frame_end,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [HW+1:0] out_x,
    output logic [VW+1:0] out_y,
    output logic [2:0]    out_scale,
    output logic [GW-1:0] out_grade,
    output logic          out_last,
    output logic          frame_done,
    output logic [3:0]    det_count,
    output logic [7:0]    drop_count,
    output logic          frame_overrun
);
    localparam int CW = $clog2(MAX_DET + 1);
    localparam int IW = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;
    localparam logic signed [GW-1:0] TH = GW'(GRADE_TH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DUMP = 1'b1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) return v + 8'd1;
        return v;
    endfunction

    // collect table
    logic signed [GW-1:0] tg_q [MAX_DET];
    logic signed [GW-1:0] tg_d [MAX_DET];
    logic [HW+1:0]        tx_q [MAX_DET];
    logic [HW+1:0]        tx_d [MAX_DET];
    logic [VW+1:0]        ty_q [MAX_DET];
    logic [VW+1:0]        ty_d [MAX_DET];
    logic [2:0]           ts_q [MAX_DET];
    logic [2:0]           ts_d [MAX_DET];
    logic [CW-1:0]        tcnt_q, tcnt_d;
    logic [7:0]           drop_q, drop_d;

    // output bank
    logic signed [GW-1:0] bg_q [MAX_DET];
    logic signed [GW-1:0] bg_d [MAX_DET];
    logic [HW+1:0]        bx_q [MAX_DET];
    logic [HW+1:0]        bx_d [MAX_DET];
    logic [VW+1:0]        by_q [MAX_DET];
    logic [VW+1:0]        by_d [MAX_DET];
    logic [2:0]           bs_q [MAX_DET];
    logic [2:0]           bs_d [MAX_DET];
    logic [CW-1:0]        bcnt_q, bcnt_d;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] det_q, det_d;
    logic [7:0]    dropo_q, dropo_d;
    logic          fd_q, fd_d;
    logic          ovr_q, ovr_d;

    logic signed [GW-1:0] in_grade;
    logic                 scale_ok, accept, full, insert, drop_inc, xfer, at_last;
    logic [1:0]           sh;
    logic [HW+1:0]        new_x;
    logic [VW+1:0]        new_y;
    logic [CW-1:0]        pos, icnt;
    logic [7:0]           idrop;

    // Accept, parallel compare and single-cycle insert/shift
    always_comb begin
        in_grade = svm_judge_res_grade;
        scale_ok = (svm_judge_res_scale == 3'd1) || (svm_judge_res_scale == 3'd2) ||
                   (svm_judge_res_scale == 3'd4);
        case (svm_judge_res_scale)
            3'd2:    sh = 2'd1;
            3'd4:    sh = 2'd2;
            default: sh = 2'd0;
        endcase
        new_x  = {2'b00, svm_judge_HCnt} << sh;
        new_y  = {2'b00, svm_judge_VCnt} << sh;
        accept = svm_judge_res && scale_ok && (in_grade >= TH);
        full   = (tcnt_q == CW'(MAX_DET));
        // Counting ">=" places the newcomer after every equal grade already held.
        pos = '0;
        for (int i = 0; i < MAX_DET; i++) begin
            if ((CW'(i) < tcnt_q) && (tg_q[i] >= in_grade)) pos = pos + 1'b1;
        end
        insert   = accept && !(full && (pos == CW'(MAX_DET)));
        drop_inc = svm_judge_res && (!accept || full);
        for (int i = 0; i < MAX_DET; i++) begin
            tg_d[i] = tg_q[i];
            tx_d[i] = tx_q[i];
            ty_d[i] = ty_q[i];
            ts_d[i] = ts_q[i];
        end
        if (insert) begin
            for (int i = MAX_DET - 1; i > 0; i--) begin
                if (CW'(i) > pos) begin
                    tg_d[i] = tg_q[i-1];
                    tx_d[i] = tx_q[i-1];
                    ty_d[i] = ty_q[i-1];
                    ts_d[i] = ts_q[i-1];
                end
            end
            for (int i = 0; i < MAX_DET; i++) begin
                if (CW'(i) == pos) begin
                    tg_d[i] = in_grade;
                    tx_d[i] = new_x;
                    ty_d[i] = new_y;
                    ts_d[i] = svm_judge_res_scale;
                end
            end
        end
        icnt   = (insert && !full) ? tcnt_q + 1'b1 : tcnt_q;
        idrop  = sat_inc(drop_q, drop_inc);
        tcnt_d = frame_end ? '0 : icnt;
        drop_d = frame_end ? 8'd0 : idrop;
    end

    // Snapshot: the bank takes the table including a same-cycle detection
    always_comb begin
        for (int i = 0; i < MAX_DET; i++) begin
            bg_d[i] = frame_end ? tg_d[i] : bg_q[i];
            bx_d[i] = frame_end ? tx_d[i] : bx_q[i];
            by_d[i] = frame_end ? ty_d[i] : by_q[i];
            bs_d[i] = frame_end ? ts_d[i] : bs_q[i];
        end
        bcnt_d  = frame_end ? icnt : bcnt_q;
        det_d   = frame_end ? icnt : det_q;
        dropo_d = frame_end ? idrop : dropo_q;
        fd_d    = frame_end;
    end

    // Output FSM
    always_comb begin
        xfer    = (state_q == DUMP) && out_ready;
        at_last = (CW'(idx_q) == bcnt_q - 1'b1);
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = 1'b0;
        if (xfer) begin
            if (at_last) state_d = IDLE;
            else         idx_d   = idx_q + 1'b1;
        end
        if (frame_end) begin
            ovr_d   = (state_q == DUMP) && !(xfer && at_last);
            idx_d   = '0;
            state_d = (icnt != '0) ? DUMP : IDLE;
        end
    end

    always_ff @(posedge RGB565_PCLK) begin
        tg_q <= tg_d;
        tx_q <= tx_d;
        ty_q <= ty_d;
        ts_q <= ts_d;
        bg_q <= bg_d;
        bx_q <= bx_d;
        by_q <= by_d;
        bs_q <= bs_d;
    end

    always_ff @(posedge RGB565_PCLK or negedge RESETN) begin
        if (!RESETN) begin
            tcnt_q  <= '0;
            drop_q  <= 8'd0;
            bcnt_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            det_q   <= '0;
            dropo_q <= 8'd0;
            fd_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            drop_q  <= drop_d;
            bcnt_q  <= bcnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            det_q   <= det_d;
            dropo_q <= dropo_d;
            fd_q    <= fd_d;
            ovr_q   <= ovr_d;
        end
    end

    // Fields read as zero whenever nothing is being presented
    assign out_valid     = (state_q == DUMP);
    assign out_last      = out_valid && at_last;
    assign out_x         = out_valid ? bx_q[idx_q] : '0;
    assign out_y         = out_valid ? by_q[idx_q] : '0;
    assign out_scale     = out_valid ? bs_q[idx_q] : 3'd0;
    assign out_grade     = out_valid ? bg_q[idx_q] : '0;
    assign frame_done    = fd_q;
    assign det_count     = 4'(det_q);
    assign drop_count    = dropo_q;
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_pd_result_collector.sv
// Bench for pd_result_collector: directed vectors, multi-cycle corner sequences and a
// randomized run against a queue-based reference model.
module tb_pd_result_collector;
    localparam int MAX_DET = 8;

    logic        RGB565_PCLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        svm_judge_res = 1'b0;
    logic [2:0]  svm_judge_res_scale = 3'd0;
    logic [9:0]  svm_judge_HCnt = 10'd0;
    logic [9:0]  svm_judge_VCnt = 10'd0;
    logic [15:0] svm_judge_res_grade = 16'd0;
    logic        frame_end = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, frame_done, frame_overrun;
    logic [11:0] out_x, out_y;
    logic [2:0]  out_scale;
    logic [15:0] out_grade;
    logic [3:0]  det_count;
    logic [7:0]  drop_count;

    pd_result_collector dut (
        .RGB565_PCLK(RGB565_PCLK), .RESETN(RESETN), .svm_judge_res(svm_judge_res),
        .svm_judge_res_scale(svm_judge_res_scale), .svm_judge_HCnt(svm_judge_HCnt),
        .svm_judge_VCnt(svm_judge_VCnt), .svm_judge_res_grade(svm_judge_res_grade),
        .frame_end(frame_end), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .out_grade(out_grade),
        .out_last(out_last), .frame_done(frame_done), .det_count(det_count),
        .drop_count(drop_count), .frame_overrun(frame_overrun)
    );

    always #5 RGB565_PCLK = ~RGB565_PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  s;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] g;
        bit          acc;
        logic [11:0] x;
        logic [11:0] y;
    } vec_t;

    typedef struct {
        int g;
        int x;
        int y;
        int s;
    } det_t;

    vec_t vt[10];
    det_t coll[$];
    det_t outq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge RGB565_PCLK);
        #1;
    endtask

    task automatic drive_det(input logic [2:0] s, input logic [9:0] h, input logic [9:0] v,
                             input logic [15:0] g);
        svm_judge_res       = 1'b1;
        svm_judge_res_scale = s;
        svm_judge_HCnt      = h;
        svm_judge_VCnt      = v;
        svm_judge_res_grade = g;
        step();
        svm_judge_res = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic expect_entry(input string name, input logic [15:0] g, input logic [11:0] x,
                                input logic [11:0] y, input logic [2:0] s, input bit last);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_grade"}, 32'(out_grade), 32'(g));
        chk({name, "_x"}, 32'(out_x), 32'(x));
        chk({name, "_y"}, 32'(out_y), 32'(y));
        chk({name, "_scale"}, 32'(out_scale), 32'(s));
        chk({name, "_last"}, 32'(out_last), 32'(last));
        step();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && out_valid; i++) step();
        chk({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd1, 10'd0,    10'd0,    16'd0,      1'b1, 12'd0,    12'd0};
        vt[1] = '{3'd2, 10'd1023, 10'd1023, 16'd100,    1'b1, 12'd2046, 12'd2046};
        vt[2] = '{3'd4, 10'd1023, 10'd1023, 16'd1,      1'b1, 12'd4092, 12'd4092};
        vt[3] = '{3'd4, 10'd3,    10'd9,    16'h7FFF,   1'b1, 12'd12,   12'd36};
        vt[4] = '{3'd1, 10'd1,    10'd1,    16'hFFFF,   1'b0, 12'd0,    12'd0};
        vt[5] = '{3'd0, 10'd1,    10'd1,    16'd5,      1'b0, 12'd0,    12'd0};
        vt[6] = '{3'd3, 10'd1,    10'd1,    16'd5,      1'b0, 12'd0,    12'd0};
        vt[7] = '{3'd5, 10'd1,    10'd1,    16'd5,      1'b0, 12'd0,    12'd0};
        vt[8] = '{3'd2, 10'd5,    10'd6,    16'h8000,   1'b0, 12'd0,    12'd0};
        vt[9] = '{3'd1, 10'd517,  10'd300,  16'd77,     1'b1, 12'd517,  12'd300};

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_overrun", 32'(frame_overrun), 32'd0);
        chk("rst_det_count", 32'(det_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_scale", 32'(out_scale), 32'd0);
        chk("rst_out_grade", 32'(out_grade), 32'd0);
        RESETN = 1'b1;
        step();

        // Single-detection frames: acceptance rules and coordinate mapping
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_det(vt[k].s, vt[k].h, vt[k].v, vt[k].g);
            fend();
            chk($sformatf("vec%0d_frame_done", k), 32'(frame_done), 32'd1);
            chk($sformatf("vec%0d_det", k), 32'(det_count), vt[k].acc ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_drop", k), 32'(drop_count), vt[k].acc ? 32'd0 : 32'd1);
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vt[k].acc));
            if (vt[k].acc)
                expect_entry($sformatf("vec%0d", k), vt[k].g, vt[k].x, vt[k].y, vt[k].s, 1'b1);
            chk($sformatf("vec%0d_after", k), 32'(out_valid), 32'd0);
        end

        // Three detections, mixed scales
        drive_det(3'd1, 10'd10, 10'd20, 16'd50);
        drive_det(3'd2, 10'd30, 10'd40, 16'd200);
        drive_det(3'd4, 10'd5, 10'd7, 16'd120);
        fend();
        chk("three_frame_done", 32'(frame_done), 32'd1);
        chk("three_det", 32'(det_count), 32'd3);
        chk("three_drop", 32'(drop_count), 32'd0);
        expect_entry("three_e0", 16'd200, 12'd60, 12'd80, 3'd2, 1'b0);
        expect_entry("three_e1", 16'd120, 12'd20, 12'd28, 3'd4, 1'b0);
        expect_entry("three_e2", 16'd50, 12'd10, 12'd20, 3'd1, 1'b1);
        chk("three_end_valid", 32'(out_valid), 32'd0);
        chk("three_fd_pulse", 32'(frame_done), 32'd0);

        // Ten back-to-back, table overflows
        for (int i = 1; i <= 10; i++) drive_det(3'd1, 10'(i), 10'd0, 16'(i));
        fend();
        chk("ten_det", 32'(det_count), 32'd8);
        chk("ten_drop", 32'(drop_count), 32'd2);
        for (int k = 0; k < 8; k++)
            expect_entry($sformatf("ten_e%0d", k), 16'(10 - k), 12'(10 - k), 12'd0, 3'd1, k == 7);
        drain("ten");

        // Rejection and stable ties
        drive_det(3'd1, 10'd0, 10'd0, 16'hFFFB);
        drive_det(3'd3, 10'd0, 10'd0, 16'd7);
        drive_det(3'd1, 10'd1, 10'd3, 16'd9);
        drive_det(3'd1, 10'd2, 10'd3, 16'd9);
        fend();
        chk("tie_det", 32'(det_count), 32'd2);
        chk("tie_drop", 32'(drop_count), 32'd2);
        expect_entry("tie_e0", 16'd9, 12'd1, 12'd3, 3'd1, 1'b0);
        expect_entry("tie_e1", 16'd9, 12'd2, 12'd3, 3'd1, 1'b1);
        drain("tie");

        // Backpressure holds the presented entry
        out_ready = 1'b0;
        drive_det(3'd1, 10'd1, 10'd0, 16'd30);
        drive_det(3'd1, 10'd2, 10'd0, 16'd20);
        drive_det(3'd1, 10'd3, 10'd0, 16'd10);
        fend();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_x", k), 32'(out_x), 32'd1);
            chk($sformatf("stall%0d_grade", k), 32'(out_grade), 32'd30);
            step();
        end
        out_ready = 1'b1;
        expect_entry("stall_e0", 16'd30, 12'd1, 12'd0, 3'd1, 1'b0);
        expect_entry("stall_e1", 16'd20, 12'd2, 12'd0, 3'd1, 1'b0);
        expect_entry("stall_e2", 16'd10, 12'd3, 12'd0, 3'd1, 1'b1);
        chk("stall_end_valid", 32'(out_valid), 32'd0);

        // Overrun: new snapshot during an unfinished dump
        for (int i = 0; i < 4; i++) drive_det(3'd1, 10'(i), 10'd0, 16'(40 + i));
        fend();
        expect_entry("ovr_old0", 16'd43, 12'd3, 12'd0, 3'd1, 1'b0);
        out_ready = 1'b0;
        chk("ovr_old1_grade", 32'(out_grade), 32'd42);
        drive_det(3'd1, 10'd7, 10'd0, 16'd33);
        drive_det(3'd1, 10'd8, 10'd0, 16'd44);
        fend();
        chk("ovr_pulse", 32'(frame_overrun), 32'd1);
        chk("ovr_frame_done", 32'(frame_done), 32'd1);
        chk("ovr_det", 32'(det_count), 32'd2);
        out_ready = 1'b1;
        expect_entry("ovr_new0", 16'd44, 12'd8, 12'd0, 3'd1, 1'b0);
        chk("ovr_pulse_end", 32'(frame_overrun), 32'd0);
        expect_entry("ovr_new1", 16'd33, 12'd7, 12'd0, 3'd1, 1'b1);
        chk("ovr_end_valid", 32'(out_valid), 32'd0);

        // Detection coinciding with frame_end, then an empty frame
        drive_det(3'd1, 10'd1, 10'd0, 16'd5);
        svm_judge_res       = 1'b1;
        svm_judge_res_scale = 3'd1;
        svm_judge_HCnt      = 10'd2;
        svm_judge_VCnt      = 10'd0;
        svm_judge_res_grade = 16'd6;
        frame_end           = 1'b1;
        step();
        svm_judge_res = 1'b0;
        frame_end     = 1'b0;
        chk("coin_det", 32'(det_count), 32'd2);
        chk("coin_drop", 32'(drop_count), 32'd0);
        expect_entry("coin_e0", 16'd6, 12'd2, 12'd0, 3'd1, 1'b0);
        expect_entry("coin_e1", 16'd5, 12'd1, 12'd0, 3'd1, 1'b1);
        fend();
        chk("empty_frame_done", 32'(frame_done), 32'd1);
        chk("empty_det", 32'(det_count), 32'd0);
        chk("empty_valid", 32'(out_valid), 32'd0);
        step();
        chk("empty_valid_next", 32'(out_valid), 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) drive_det(3'd3, 10'd0, 10'd0, 16'd1);
        fend();
        chk("sat_drop", 32'(drop_count), 32'd255);
        chk("sat_det", 32'(det_count), 32'd0);

        // Reset in the middle of a dump
        out_ready = 1'b0;
        drive_det(3'd1, 10'd1, 10'd0, 16'd11);
        drive_det(3'd1, 10'd2, 10'd0, 16'd12);
        fend();
        chk("rstdump_valid_before", 32'(out_valid), 32'd1);
        #1;
        RESETN = 1'b0;
        #1;
        chk("rstdump_valid", 32'(out_valid), 32'd0);
        chk("rstdump_det", 32'(det_count), 32'd0);
        chk("rstdump_fd", 32'(frame_done), 32'd0);
        step();
        RESETN    = 1'b1;
        out_ready = 1'b1;
        step();
        drive_det(3'd2, 10'd3, 10'd4, 16'd15);
        fend();
        chk("rstdump_new_det", 32'(det_count), 32'd1);
        chk("rstdump_new_drop", 32'(drop_count), 32'd0);
        expect_entry("rstdump_e0", 16'd15, 12'd6, 12'd8, 3'd2, 1'b1);
        chk("rstdump_end_valid", 32'(out_valid), 32'd0);

        // Randomized run against the reference model
        pulse_reset();
        begin
            int  m_drop = 0;
            int  e_det = 0;
            int  e_drop = 0;
            bit  e_fd = 0;
            bit  e_ovr = 0;
            coll.delete();
            outq.delete();
            for (int cyc = 0; cyc < 2500; cyc++) begin
                bit  res, fe, rdy, pre_valid, lastx;
                int  s, h, v, g, r;
                chk("rnd_valid", 32'(out_valid), 32'(outq.size() > 0));
                if (outq.size() > 0) begin
                    chk("rnd_x", 32'(out_x), 32'(outq[0].x));
                    chk("rnd_y", 32'(out_y), 32'(outq[0].y));
                    chk("rnd_scale", 32'(out_scale), 32'(outq[0].s));
                    chk("rnd_grade", 32'(out_grade), 32'(16'(outq[0].g)));
                    chk("rnd_last", 32'(out_last), 32'(outq.size() == 1));
                end
                chk("rnd_frame_done", 32'(frame_done), 32'(e_fd));
                chk("rnd_overrun", 32'(frame_overrun), 32'(e_ovr));
                chk("rnd_det", 32'(det_count), 32'(e_det));
                chk("rnd_drop", 32'(drop_count), 32'(e_drop));

                res = ($urandom_range(0, 1) == 1);
                r   = int'($urandom_range(0, 9));
                s   = (r < 3) ? 1 : (r < 6) ? 2 : (r < 9) ? 4 : int'($urandom_range(0, 7));
                h   = int'($urandom_range(0, 1023));
                v   = int'($urandom_range(0, 1023));
                g   = int'($urandom_range(0, 24)) - 4;
                fe  = ($urandom_range(0, 29) == 0);
                rdy = ($urandom_range(0, 3) != 0);

                svm_judge_res       = res;
                svm_judge_res_scale = 3'(s);
                svm_judge_HCnt      = 10'(h);
                svm_judge_VCnt      = 10'(v);
                svm_judge_res_grade = 16'(g);
                frame_end           = fe;
                out_ready           = rdy;

                pre_valid = (outq.size() > 0);
                lastx     = pre_valid && rdy && (outq.size() == 1);
                e_fd      = 0;
                e_ovr     = 0;
                if (res) begin
                    if (!(s == 1 || s == 2 || s == 4) || g < 0) begin
                        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    end else begin
                        det_t d;
                        int   pos;
                        int   mul;
                        mul = (s == 1) ? 1 : (s == 2) ? 2 : 4;
                        d.g = g;
                        d.x = h * mul;
                        d.y = v * mul;
                        d.s = s;
                        pos = coll.size();
                        for (int i = coll.size() - 1; i >= 0; i--)
                            if (coll[i].g < g) pos = i;
                        if (coll.size() == MAX_DET && pos == MAX_DET) begin
                            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                        end else begin
                            coll.insert(pos, d);
                            if (coll.size() > MAX_DET) begin
                                void'(coll.pop_back());
                                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                            end
                        end
                    end
                end
                if (pre_valid && rdy) void'(outq.pop_front());
                if (fe) begin
                    e_ovr  = pre_valid && !lastx;
                    outq   = coll;
                    e_det  = coll.size();
                    e_drop = m_drop;
                    e_fd   = 1;
                    coll.delete();
                    m_drop = 0;
                end
                step();
            end
        end
        svm_judge_res = 1'b0;
        frame_end     = 1'b0;
        out_ready     = 1'b1;
        drain("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
